des_key_schedule: RTL
=====================

Name: des_key_schedule

Overview:
Generates the sixteen 48-bit DES round subkeys from a 64-bit key, one per accepted handshake, in encrypt order (K1..K16) or decrypt order (K16..K1).
Sits directly upstream of the S-box stage. Each subkey is XORed with the 48-bit expanded right half, and the result forms the eight 6-bit S-box inputs (S1..S8).
Bit numbering follows FIPS 46-3 throughout: bit 1 is the MSB.

Parameters:
None. All tables (PC-1, PC-2, shift schedule) are fixed by FIPS 46-3.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
key_in  input  64  DES key; parity bits 8,16,..,64 are ignored
key_load  input  1  start request; sampled only in IDLE
decrypt  input  1  0 = encrypt order, 1 = decrypt order; sampled with key_load
busy  output  1  1 while in RUN
subkey_valid  output  1  subkey_o/round_o are valid
subkey_ready  input  1  consumer accepts the current subkey
subkey_o  output  48  PC-2(C,D) of the current step
round_o  output  4  step index 0..15 (step s = round_o+1)
done  output  1  one-cycle pulse after the 16th subkey is accepted

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; C=0; D=0; step=0; dir=0.
  - busy=0, subkey_valid=0, done=0, round_o=0, subkey_o=PC-2(0,0)=0.
  - Reset mid-RUN aborts immediately; no done pulse.
- States: IDLE, RUN.
- IDLE, key_load=1:
  - Compute {C,D} = PC-1(key_in), two 28-bit halves.
  - Register dir=decrypt.
  - Encrypt: store C,D rotated left by 1. Decrypt: store C,D unrotated.
  - step=0; state=RUN.
  - Latency is 1 cycle: subkey_valid=1 in the cycle after key_load.
- RUN outputs: subkey_valid=busy=1; subkey_o=PC-2(C,D); round_o=step.
- RUN, subkey_valid & subkey_ready (transfer):
  - step<15: step+1 and update C,D.
    - Encrypt: rotate left by SHIFT[step+2].
    - Decrypt: rotate right by SHIFT[16-step].
  - step==15: state=IDLE; subkey_valid=0; done=1 for one cycle.
- Shift schedule: SHIFT[r]=1 for r in {1,2,9,16}, otherwise 2. The total over 16 rounds is 28, so C16=C0 and D16=D0.
  - Encrypt step s delivers K(s).
  - Decrypt step s delivers K(17-s).
- RUN, subkey_ready=0: all state and outputs hold; subkey_o is stable while valid and not accepted.
- key_load during RUN or in the done cycle's RUN state: ignored. key_load in the cycle done=1 (state is already IDLE) is accepted.
- Maximum throughput is one subkey per cycle, so a full schedule takes 16 cycles plus 1 load cycle.
- Rotations act on each 28-bit half independently (wrap-around within the half).

Decomposition:
- des_pkg:
  - PC1 table (56 entries), PC2 table (48 entries), SHIFT[1:16].
  - State encoding localparams ST_IDLE, ST_RUN.
  - Rotate-left/right-by-n helper functions for 28-bit halves.
- Sub-module des_pc2: combinational 56->48 permutation, instanced once on the {C,D} registers.
- PC-1 is applied inline at load.

Test Plan:
- Encrypt ordering:
  - Stimulus: key 0x133457799BBCDFF1, decrypt=0, subkey_ready=1.
  - Response: round_o=0 -> subkey_o=0x1B02EFFC7072; round_o=15 -> 0xCB3D8B0E17F5; done pulses 16 cycles after the first valid.
- Decrypt ordering:
  - Stimulus: same key, decrypt=1.
  - Response: round_o=0 -> 0xCB3D8B0E17F5; round_o=15 -> 0x1B02EFFC7072; all 16 subkeys match the encrypt run in reverse order.
- Backpressure:
  - Stimulus: key 0x133457799BBCDFF1, encrypt; subkey_ready toggled 1,0,0,1,...
  - Response: subkey_o/round_o hold while ready=0; no skipped or duplicated subkey; done only after the 16th transfer.
- Degenerate keys and parity bits:
  - Key 0x0000000000000000 -> all 16 subkeys 0x000000000000.
  - Key 0xFFFFFFFFFFFFFFFF -> all 16 subkeys 0xFFFFFFFFFFFF.
  - Key 0x0101010101010101 (parity bits only) -> all subkeys 0.
- Ignored load:
  - Stimulus: key_load=1 with a different key at round_o=5.
  - Response: sequence continues unchanged for the original key.
- Reset mid-operation:
  - Stimulus: rst=1 at round_o=7.
  - Response: next cycle busy=0, subkey_valid=0, done=0, round_o=0; a fresh load afterwards yields K1=0x1B02EFFC7072 one cycle later.

Source files
------------

// File: rtl/des_key_schedule_pkg.sv
// DES key-schedule constants: PC-1/PC-2 selection tables, per-round shift counts,
// FSM state encoding and 28-bit half rotation helpers. Table entries use FIPS bit numbering (1 = MSB).
package des_key_schedule_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  localparam logic [1:0] SHIFT [1:16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // The schedule only ever rotates by 1 or 2; other amounts leave the half untouched.
  function automatic logic [27:0] rol28(input logic [27:0] x, input logic [1:0] n);
    logic [27:0] r;
    case (n)
      2'd1:    r = {x[26:0], x[27]};
      2'd2:    r = {x[25:0], x[27:26]};
      default: r = x;
    endcase
    return r;
  endfunction

  function automatic logic [27:0] ror28(input logic [27:0] x, input logic [1:0] n);
    logic [27:0] r;
    case (n)
      2'd1:    r = {x[0], x[27:1]};
      2'd2:    r = {x[1:0], x[27:2]};
      default: r = x;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/des_key_schedule_if.sv
// Key-load request and subkey valid/ready stream between the key schedule and its consumer.
interface des_key_schedule_if;
  logic [63:0] key_in;
  logic        key_load;
  logic        decrypt;
  logic        busy;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [47:0] subkey_o;
  logic [3:0]  round_o;
  logic        done;

  modport master (
    output key_in, key_load, decrypt, subkey_ready,
    input  busy, subkey_valid, subkey_o, round_o, done
  );

  modport slave (
    input  key_in, key_load, decrypt, subkey_ready,
    output busy, subkey_valid, subkey_o, round_o, done
  );
endinterface

// File: rtl/des_key_schedule_pc2.sv
// Combinational PC-2: selects 48 of the 56 {C,D} bits to form one round subkey.
module des_key_schedule_pc2
  import des_key_schedule_pkg::*;
(
  input  logic [55:0] cd_i,
  output logic [47:0] k_o
);

  // Bits 9,18,22,25,35,38,43,54 of {C,D} never reach the subkey.
  logic [7:0] dropped_unused;

  genvar gi;
  generate
    for (gi = 0; gi < 48; gi++) begin : g_sel
      assign k_o[47-gi] = cd_i[56-PC2[gi]];
    end
  endgenerate

  assign dropped_unused = {cd_i[47], cd_i[38], cd_i[34], cd_i[31],
                           cd_i[21], cd_i[18], cd_i[13], cd_i[2]};

endmodule

// File: rtl/des_key_schedule.sv
// DES key schedule: streams K1..K16 (encrypt) or K16..K1 (decrypt) over a valid/ready
// handshake, one subkey per transfer, with a one-cycle done pulse after the last one.
module des_key_schedule
  import des_key_schedule_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  des_key_schedule_if.slave bus
);

  state_e      state_q, state_d;
  logic [27:0] c_q, c_d;
  logic [27:0] d_q, d_d;
  logic [3:0]  step_q, step_d;
  logic        dir_q, dir_d;
  logic        done_q, done_d;

  logic [55:0] pc1_key;
  logic [7:0]  parity_unused;
  logic [47:0] subkey;

  genvar gi;
  generate
    for (gi = 0; gi < 56; gi++) begin : g_pc1
      assign pc1_key[55-gi] = bus.key_in[64-PC1[gi]];
    end
    for (gi = 0; gi < 8; gi++) begin : g_parity
      assign parity_unused[gi] = bus.key_in[8*gi];
    end
  endgenerate

  des_key_schedule_pc2 u_pc2 (
    .cd_i ({c_q, d_q}),
    .k_o  (subkey)
  );

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    step_d  = step_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.key_load) begin
          // Decrypt starts from C16/D16, which equal the unrotated C0/D0.
          if (bus.decrypt) begin
            c_d = pc1_key[55:28];
            d_d = pc1_key[27:0];
          end else begin
            c_d = rol28(pc1_key[55:28], SHIFT[1]);
            d_d = rol28(pc1_key[27:0], SHIFT[1]);
          end
          dir_d   = bus.decrypt;
          step_d  = 4'd0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.subkey_ready) begin
          if (step_q == 4'd15) begin
            state_d = ST_IDLE;
            step_d  = 4'd0;
            done_d  = 1'b1;
          end else begin
            step_d = step_q + 4'd1;
            if (dir_q) begin
              c_d = ror28(c_q, SHIFT[5'd16 - {1'b0, step_q}]);
              d_d = ror28(d_q, SHIFT[5'd16 - {1'b0, step_q}]);
            end else begin
              c_d = rol28(c_q, SHIFT[{1'b0, step_q} + 5'd2]);
              d_d = rol28(d_q, SHIFT[{1'b0, step_q} + 5'd2]);
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      c_q     <= '0;
      d_q     <= '0;
      step_q  <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy         = (state_q == ST_RUN);
  assign bus.subkey_valid = (state_q == ST_RUN);
  assign bus.subkey_o     = subkey;
  assign bus.round_o      = step_q;
  assign bus.done         = done_q;

endmodule
